// File: rtl/spi_slave_responder.sv
// SPI slave responder: MOSI bytes to host, MISO bytes from a TX FIFO.
// Optional SPI_SLAVE_ECHO_EN: an empty FIFO echoes the last received byte.
module spi_slave_responder #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF,
  parameter bit         CPOL       = 1'b0,
  parameter bit         CPHA       = 1'b0
) (
  input  logic       clk30,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       underrun,
  output logic       aborted,
  input  logic       clr_flags
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_n;

  logic [1:0] sck_q, mosi_q, ss_q;
  logic       sck_d, ss_d;
  logic       sck_s, mosi_s, ss_s;
  logic       lead, trail, sample_edge, shift_edge;
  logic       ss_fall, ss_rise;

  logic [3:0] bitcnt;
  logic [7:0] shift_tx;
  logic [6:0] shift_rx;
  logic [7:0] load_byte;
  logic       pop_req, do_sample, do_shift, go_idle;
  logic       set_under, set_abort;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_n;
  logic          push, pop, empty;

  assign sck_s  = sck_q[1];
  assign mosi_s = mosi_q[1];
  assign ss_s   = ss_q[1];

  always_ff @(posedge clk30 or negedge rst) begin
    if (!rst) begin
      sck_q  <= {2{CPOL}};
      mosi_q <= 2'b00;
      ss_q   <= 2'b11;
      sck_d  <= CPOL;
      ss_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[0], sck};
      mosi_q <= {mosi_q[0], mosi};
      ss_q   <= {ss_q[0], ss_n};
      sck_d  <= sck_s;
      ss_d   <= ss_s;
    end
  end

  assign lead        = (sck_s != CPOL) && (sck_d == CPOL);
  assign trail       = (sck_s == CPOL) && (sck_d != CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign ss_fall     = !ss_s && ss_d;
  assign ss_rise     = ss_s && !ss_d;
  assign miso_oe     = ~ss_s;

  always_ff @(posedge clk30 or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pop_req   = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    go_idle   = 1'b0;
    if (ss_rise) begin
      state_n = IDLE;
      go_idle = 1'b1;
    end else begin
      unique case (state)
        IDLE: if (ss_fall) state_n = LOAD;
        LOAD: begin
          pop_req = 1'b1;
          state_n = SHIFT;
        end
        SHIFT: begin
          if (sample_edge) begin
            do_sample = 1'b1;
            if (CPHA && bitcnt == 4'd7) state_n = LOAD;
          end
          if (shift_edge) begin
            if (!CPHA && bitcnt == 4'd8) state_n = LOAD;
            else                         do_shift = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign empty = (count == '0);
  assign pop   = pop_req && !empty;
  assign push  = tx_valid && (tx_ready || pop);

`ifdef SPI_SLAVE_ECHO_EN
  logic have_rx;
  assign set_under = 1'b0;
  always_comb begin
    load_byte = mem[rptr];
    if (empty) load_byte = have_rx ? rx_data : IDLE_BYTE;
  end
  always_ff @(posedge clk30 or negedge rst) begin
    if (!rst)                            have_rx <= 1'b0;
    else if (do_sample && bitcnt == 4'd7) have_rx <= 1'b1;
  end
`else
  assign set_under = pop_req && empty;
  always_comb begin
    load_byte = mem[rptr];
    if (empty) load_byte = IDLE_BYTE;
  end
`endif

  // A partial byte at deselect counts as an abort; 0 or 8 bits is clean.
  assign set_abort = go_idle && bitcnt != 4'd0 && bitcnt != 4'd8;

  always_ff @(posedge clk30 or negedge rst) begin
    if (!rst) begin
      miso     <= 1'b1;
      bitcnt   <= 4'd0;
      shift_tx <= IDLE_BYTE;
      shift_rx <= 7'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (go_idle) begin
        miso   <= 1'b1;
        bitcnt <= 4'd0;
      end
      if (pop_req) begin
        shift_tx <= load_byte;
        bitcnt   <= 4'd0;
        if (!CPHA) miso <= load_byte[7];
      end
      if (do_sample) begin
        shift_rx <= {shift_rx[5:0], mosi_s};
        bitcnt   <= bitcnt + 4'd1;
        if (bitcnt == 4'd7) begin
          rx_data  <= {shift_rx, mosi_s};
          rx_valid <= 1'b1;
        end
      end
      if (do_shift) begin
        miso     <= CPHA ? shift_tx[7] : shift_tx[6];
        shift_tx <= {shift_tx[6:0], 1'b0};
      end
      underrun <= set_under | (underrun & ~clr_flags);
      aborted  <= set_abort | (aborted & ~clr_flags);
    end
  end

  always_ff @(posedge clk30) begin
    if (push) mem[wptr] <= tx_data;
  end

  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk30 or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count_n;
      tx_ready <= (count_n < DEPTH);
    end
  end
endmodule
